weight_dma: RTL and testbench

WEIGHT_DMA -- requirements
Module: weight_dma

---
 rtl/fc_pkg.sv | 19 +
 rtl/dma_burst_counter.sv | 40 ++++
 rtl/weight_dma.sv | 114 +++++++++++
 tb/tb_weight_dma.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer weight path.
package fc_pkg;

    localparam int DEF_MEM_ADDRESS_WIDTH   = 16;
    localparam int DEF_LAYER_ADDRESS_WIDTH = 7;
    localparam int DEF_DATA_WIDTH          = 16;

    // Word addresses where each layer's weight block starts in weight memory.
    localparam int ADR_LAYER_F6     = 0;
    localparam int ADR_LAYER_OUTPUT = 10164;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } dma_state_e;

endpackage

// File: rtl/dma_burst_counter.sv
// Burst issue counter: cleared on load, stepped on advance, flags the final
// read of a burst of length len_i.
module dma_burst_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en_i,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] len_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clk_en_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // A zero-length burst never enters FETCH, so len_i == 0 must not match.
    assign last_o  = (len_i != '0) && (count_q == len_i - WIDTH'(1));

endmodule

// File: rtl/weight_dma.sv
// Weight DMA: streams a burst of weight words from memory onto the FC data bus,
// word 0 of each burst being the bias.
module weight_dma
    import fc_pkg::*;
#(
    parameter int MEM_ADDRESS_WIDTH   = DEF_MEM_ADDRESS_WIDTH,
    parameter int LAYER_ADDRESS_WIDTH = DEF_LAYER_ADDRESS_WIDTH,
    parameter int DATA_WIDTH          = DEF_DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clk_en,
    input  logic                           DMA_read,
    input  logic [MEM_ADDRESS_WIDTH-1:0]   DMA_address,
    input  logic [LAYER_ADDRESS_WIDTH-1:0] DMA_count,
    output logic                           DMA_ready,
    output logic                           mem_rd,
    output logic [MEM_ADDRESS_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_data,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    output logic [LAYER_ADDRESS_WIDTH-1:0] out_index,
    output logic                           busy
);

    dma_state_e                     state_q, state_d;
    logic [MEM_ADDRESS_WIDTH-1:0]   base_q, base_d;
    logic [LAYER_ADDRESS_WIDTH-1:0] len_q, len_d;
    logic [LAYER_ADDRESS_WIDTH-1:0] idx;
    logic                           idx_last;
    logic                           cnt_load;
    logic                           cnt_advance;
    logic                           rd;
    logic                           out_valid_q;
    logic [LAYER_ADDRESS_WIDTH-1:0] out_index_q;

    dma_burst_counter #(
        .WIDTH (LAYER_ADDRESS_WIDTH)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clk_en_i  (clk_en),
        .load_i    (cnt_load),
        .advance_i (cnt_advance),
        .len_i     (len_q),
        .count_o   (idx),
        .last_o    (idx_last)
    );

    // Request inputs are only looked at in IDLE, so changes while busy are ignored.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_load    = 1'b0;
        cnt_advance = 1'b0;
        rd          = 1'b0;
        DMA_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (DMA_read) begin
                    base_d   = DMA_address;
                    len_d    = DMA_count;
                    cnt_load = 1'b1;
                    state_d  = (DMA_count != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                rd          = 1'b1;
                cnt_advance = 1'b1;
                if (idx_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                DMA_ready = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
        end else if (clk_en) begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            out_valid_q <= rd;
            if (rd) begin
                out_index_q <= idx;
            end
        end
    end

    assign mem_rd    = rd;
    assign mem_addr  = rd ? base_q + MEM_ADDRESS_WIDTH'(idx) : '0;
    // Memory data arrives one cycle after the strobe, aligned with out_valid_q.
    assign out_data  = out_valid_q ? mem_data : '0;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_weight_dma.sv
// Self-checking bench for weight_dma: table of bursts plus hand-written
// sequences for chained bursts, clock-enable stalls and mid-burst reset.
module tb_weight_dma;

    localparam int MAW = 16;
    localparam int LAW = 7;
    localparam int DW  = 16;
    localparam int HALF = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           clk_en = 1'b1;
    logic           DMA_read = 1'b0;
    logic [MAW-1:0] DMA_address = '0;
    logic [LAW-1:0] DMA_count = '0;
    logic           DMA_ready;
    logic           mem_rd;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_data = '0;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic [LAW-1:0] out_index;
    logic           busy;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [LAW-1:0] index;
        logic [DW-1:0]  data;
    } word_t;

    logic [MAW-1:0] addrQ[$];
    word_t          wordQ[$];

    logic           monOn = 1'b0;
    logic           lastEdgeEn = 1'b0;
    logic [MAW-1:0] lastRdAddr = '0;

    weight_dma dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .DMA_read    (DMA_read),
        .DMA_address (DMA_address),
        .DMA_count   (DMA_count),
        .DMA_ready   (DMA_ready),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_index   (out_index),
        .busy        (busy)
    );

    always #HALF clk = ~clk;

    // Weight memory model: word at address a holds a, one-cycle read latency, shares clk_en.
    always @(posedge clk) begin
        if (clk_en && mem_rd) mem_data <= DW'(mem_addr);
    end

    always @(posedge clk) lastEdgeEn = clk_en;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Outputs only change after an enabled edge, so stalled cycles are not re-counted.
    always @(negedge clk) begin
        if (monOn && rst && lastEdgeEn) begin
            if (mem_rd) begin
                if (addrQ.size() == 0) begin
                    checkOutput("unexpected mem_rd", 32'(mem_addr), 32'hDEAD);
                end else begin
                    checkOutput("mem_addr", 32'(mem_addr), 32'(addrQ.pop_front()));
                    lastRdAddr = mem_addr;
                end
            end
            if (out_valid) begin
                if (wordQ.size() == 0) begin
                    checkOutput("unexpected out_valid", 32'(out_index), 32'hDEAD);
                end else begin
                    word_t w;
                    w = wordQ.pop_front();
                    checkOutput("out_index", 32'(out_index), 32'(w.index));
                    checkOutput("out_data", 32'(out_data), 32'(w.data));
                end
            end
        end
    end

    task automatic pushBurst(input logic [MAW-1:0] addr, input int count);
        for (int k = 0; k < count; k++) begin
            word_t w;
            logic [MAW-1:0] a;
            a = addr + MAW'(k);
            w.index = LAW'(k);
            w.data  = DW'(a);
            addrQ.push_back(a);
            wordQ.push_back(w);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " DMA_ready"}, 32'(DMA_ready), 0);
        checkOutput({tag, " mem_rd"},    32'(mem_rd), 0);
        checkOutput({tag, " mem_addr"},  32'(mem_addr), 0);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, " out_data"},  32'(out_data), 0);
        checkOutput({tag, " out_index"}, 32'(out_index), 0);
        checkOutput({tag, " busy"},      32'(busy), 0);
    endtask

    // Issue one burst, scramble the request inputs while busy, and time DMA_ready
    // in negedges from the accepting edge; pauseAt > 0 stalls clk_en for 3 cycles.
    task automatic applyStimulus(input string name, input logic [MAW-1:0] addr,
                                 input int count, input int expDelay, input int pauseAt);
        int n;
        @(negedge clk);
        DMA_read    = 1'b1;
        DMA_address = addr;
        DMA_count   = LAW'(count);
        pushBurst(addr, count);
        @(posedge clk);
        #1;
        DMA_read    = 1'b0;
        DMA_address = ~addr;
        DMA_count   = LAW'(count + 37);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (pauseAt > 0 && n == pauseAt) clk_en = 1'b0;
            if (pauseAt > 0 && n == pauseAt + 3) clk_en = 1'b1;
            if (DMA_ready) break;
        end
        checkOutput({name, " ready delay"}, 32'(n), 32'(expDelay));
        @(negedge clk);
        checkOutput({name, " ready single pulse"}, 32'(DMA_ready), 0);
        checkOutput({name, " queue drained"}, 32'(addrQ.size() + wordQ.size()), 0);
    endtask

    typedef struct {
        string          name;
        logic [MAW-1:0] addr;
        int             count;
        int             expDelay;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int n, lastN, pulses;
        logic [MAW-1:0] addr;

        vecs[0] = '{"layer 121 from 0", 16'h0000, 121, 123};
        vecs[1] = '{"single word",      16'h1234,   1,   3};
        vecs[2] = '{"two words",        16'h0100,   2,   4};
        vecs[3] = '{"address wrap",     16'hFFFE,   4,   6};
        vecs[4] = '{"zero count",       16'h0050,   0,   1};
        vecs[5] = '{"max count 127",    16'h7F00, 127, 129};

        #1;
        checkResetOutputs("reset");
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        monOn = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].name, vecs[v].addr, vecs[v].count, vecs[v].expDelay, 0);
        end

        // Chained bursts: DMA_read held, address stepped by 121 on each DMA_ready.
        @(negedge clk);
        addr        = MAW'(fc_pkg::ADR_LAYER_F6);
        DMA_address = addr;
        DMA_count   = LAW'(121);
        DMA_read    = 1'b1;
        pushBurst(addr, 121);
        n = 0; lastN = 0; pulses = 0;
        while (pulses < 84 && n < 20000) begin
            @(negedge clk);
            n++;
            if (DMA_ready) begin
                pulses++;
                checkOutput("chained ready interval", 32'(n - lastN), (pulses == 1) ? 123 : 124);
                lastN = n;
                if (pulses < 84) begin
                    addr        = addr + MAW'(121);
                    DMA_address = addr;
                    pushBurst(addr, 121);
                end else begin
                    DMA_read = 1'b0;
                end
            end
        end
        checkOutput("chained ready pulses", 32'(pulses), 84);
        checkOutput("chained final address", 32'(lastRdAddr), 32'(10163));
        repeat (2) @(negedge clk);
        checkOutput("chained queue drained", 32'(addrQ.size() + wordQ.size()), 0);
        checkOutput("chained busy after", 32'(busy), 0);

        applyStimulus("clk_en stall", 16'h2000, 85, 90, 30);

        // Reset when word 40 of a 121-word burst is on the bus.
        @(negedge clk);
        DMA_read    = 1'b1;
        DMA_address = 16'h3000;
        DMA_count   = LAW'(121);
        pushBurst(16'h3000, 121);
        @(posedge clk);
        #1;
        DMA_read = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid && out_index == LAW'(40)) break;
        end
        checkOutput("reached word 40", 32'(n), 42);
        #1;
        rst = 1'b0;
        addrQ.delete();
        wordQ.delete();
        #1;
        checkResetOutputs("async reset");
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            if (DMA_ready || out_valid || mem_rd) pulses++;
        end
        checkOutput("quiet after reset", 32'(pulses), 0);
        applyStimulus("after reset", 16'h0400, 10, 12, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
